// File: rtl/dds_sweep_ctrl.sv
// Sequences freq/phase/amp words for the dds: amplitude soft-start, stepped frequency sweep, ramp-down.
// Registered outputs; every change is gated by the dac_start sample strobe except start/stop handling.
`timescale 1ns/1ps
module dds_sweep_ctrl #(
  parameter int FW = 20,
  parameter int PW = 10,
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [AW-1:0] amp_target,
  input  logic [AW-1:0] amp_step,
  input  logic [PW-1:0] phase_in,
  input  logic          dac_start,
  output logic [FW-1:0] freq,
  output logic [PW-1:0] phase,
  output logic [AW-1:0] amp,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, SWEEP, RAMP_DOWN} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] amp_q, amp_d;
  logic          busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // configuration captured at an accepted start
  logic [FW-1:0] f_start_q, f_start_d, f_stop_q, f_stop_d, f_step_q, f_step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [AW-1:0] amp_tgt_q, amp_tgt_d, amp_step_q, amp_step_d;
  logic          mode_q, mode_d;

  logic [AW:0]   amp_up;
  logic [AW-1:0] amp_up_sat, amp_dn_sat;
  logic [FW:0]   freq_nxt;
  logic [DW-1:0] dwell_last;

  always_comb begin
    amp_up     = {1'b0, amp_q} + {1'b0, amp_step_q};
    amp_up_sat = (amp_step_q == '0 || amp_up >= {1'b0, amp_tgt_q}) ? amp_tgt_q : amp_up[AW-1:0];
    amp_dn_sat = (amp_step_q == '0 || amp_q <= amp_step_q) ? '0 : amp_q - amp_step_q;
    freq_nxt   = {1'b0, freq_q} + {1'b0, f_step_q};
    dwell_last = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
  end

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    amp_d      = amp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    cnt_d      = cnt_q;
    f_start_d  = f_start_q;
    f_stop_d   = f_stop_q;
    f_step_d   = f_step_q;
    dwell_d    = dwell_q;
    amp_tgt_d  = amp_tgt_q;
    amp_step_d = amp_step_q;
    mode_d     = mode_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          f_start_d  = f_start;
          f_stop_d   = f_stop;
          f_step_d   = f_step;
          dwell_d    = dwell;
          amp_tgt_d  = amp_target;
          amp_step_d = amp_step;
          mode_d     = mode;
          freq_d     = f_start;
          phase_d    = phase_in;
          amp_d      = '0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          state_d = RAMP_DOWN;
        end else if (dac_start) begin
          amp_d = amp_up_sat;
          if (amp_up_sat == amp_tgt_q) begin
            cnt_d   = '0;
            state_d = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (stop) begin
          state_d = RAMP_DOWN;
        end else if (dac_start) begin
          if (cnt_q == dwell_last) begin
            cnt_d = '0;
            if (freq_nxt <= {1'b0, f_stop_q}) begin
              freq_d = freq_nxt[FW-1:0];
            end else if (mode_q) begin
              freq_d = f_start_q;
              wrap_d = 1'b1;
            end else begin
              state_d = RAMP_DOWN;
            end
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end
      RAMP_DOWN: begin
        if (dac_start) begin
          amp_d = amp_dn_sat;
          if (amp_dn_sat == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      freq_q     <= '0;
      phase_q    <= '0;
      amp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      f_start_q  <= '0;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      dwell_q    <= '0;
      amp_tgt_q  <= '0;
      amp_step_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      amp_q      <= amp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
      f_start_q  <= f_start_d;
      f_stop_q   <= f_stop_d;
      f_step_q   <= f_step_d;
      dwell_q    <= dwell_d;
      amp_tgt_q  <= amp_tgt_d;
      amp_step_q <= amp_step_d;
      mode_q     <= mode_d;
    end
  end

  assign freq  = freq_q;
  assign phase = phase_q;
  assign amp   = amp_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected output words queued as stimulus is driven, popped and checked after the edge.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0, dac_start = 1'b0;
  logic [19:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [15:0] dwell = '0;
  logic [11:0] amp_target = '0, amp_step = '0;
  logic [9:0]  phase_in = '0;
  logic [19:0] freq;
  logic [9:0]  phase;
  logic [11:0] amp;
  logic        busy, done, wrap;

  int vectors = 0;
  int miscompares = 0;
  int exp_phase = 0;

  typedef struct {
    logic [31:0] f, a, b, d, w;
  } exp_t;
  exp_t exp_q[$];

  // expected freq/amp over the first 11 ticks of the reference sweep
  int hf[11] = '{1000, 1000, 1000, 1000, 1000, 1100, 1100, 1200, 1200, 1300, 1300};
  int ha[11] = '{1024, 2048, 3072, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};

  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .amp_target(amp_target), .amp_step(amp_step), .phase_in(phase_in),
    .dac_start(dac_start), .freq(freq), .phase(phase), .amp(amp),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".freq"},  32'(freq),  e.f);
    chk({tag, ".amp"},   32'(amp),   e.a);
    chk({tag, ".busy"},  32'(busy),  e.b);
    chk({tag, ".done"},  32'(done),  e.d);
    chk({tag, ".wrap"},  32'(wrap),  e.w);
    chk({tag, ".phase"}, 32'(phase), 32'(exp_phase));
  endtask

  // called at a negedge: drive one cycle, check after the following posedge
  task automatic apply(input string tag, input int f, input int a, input int b, input int d,
                       input int w, input bit strt, input bit stp, input bit tk);
    exp_t e;
    e.f = 32'(f); e.a = 32'(a); e.b = 32'(b); e.d = 32'(d); e.w = 32'(w);
    exp_q.push_back(e);
    start = strt; stop = stp; dac_start = tk;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; dac_start = 1'b0;
    check_outs(tag);
    if (tk) repeat (8) @(negedge clk);
  endtask

  task automatic tick_chk(input string tag, input int f, input int a, input int b, input int d, input int w);
    apply(tag, f, a, b, d, w, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cfg(input int fs, input int fe, input int fst, input int dw,
                     input int at, input int as, input int ph, input bit md);
    f_start = 20'(fs); f_stop = 20'(fe); f_step = 20'(fst); dwell = 16'(dw);
    amp_target = 12'(at); amp_step = 12'(as); phase_in = 10'(ph); mode = md;
    exp_phase = ph;
  endtask

  task automatic sweep_head(input string tag, input int n);
    apply({tag, ".start"}, 1000, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick_chk($sformatf("%s.t%0d", tag, i + 1), hf[i], ha[i], 1, 0, 0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".freq"},  32'(freq),  32'd0);
    chk({tag, ".phase"}, 32'(phase), 32'd0);
    chk({tag, ".amp"},   32'(amp),   32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
    chk({tag, ".done"},  32'(done),  32'd0);
    chk({tag, ".wrap"},  32'(wrap),  32'd0);
  endtask

  initial begin
    // reset and idle
    #1 rst = 1'b0;
    #98 zero_chk("rst");
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) tick_chk("idle", 0, 0, 0, 0, 0);

    // single sweep
    cfg(1000, 1300, 100, 2, 4095, 1024, 100, 1'b0);
    sweep_head("single", 11);
    tick_chk("single.t12", 1300, 4095, 1, 0, 0);
    tick_chk("single.t13", 1300, 3071, 1, 0, 0);
    tick_chk("single.t14", 1300, 2047, 1, 0, 0);
    tick_chk("single.t15", 1300, 1023, 1, 0, 0);
    tick_chk("single.t16", 1300, 0, 0, 1, 0);
    apply("single.after", 1300, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // continuous wrap, then abort on a tick at freq=1100
    cfg(1000, 1300, 100, 2, 4095, 1024, 100, 1'b1);
    sweep_head("cont", 11);
    tick_chk("cont.wrap", 1000, 4095, 1, 0, 1);
    apply("cont.wrap_end", 1000, 4095, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    tick_chk("cont.t13", 1000, 4095, 1, 0, 0);
    tick_chk("cont.t14", 1100, 4095, 1, 0, 0);
    apply("abort.stop", 1100, 4095, 1, 0, 0, 1'b0, 1'b1, 1'b1);
    tick_chk("abort.d1", 1100, 3071, 1, 0, 0);
    tick_chk("abort.d2", 1100, 2047, 1, 0, 0);
    tick_chk("abort.d3", 1100, 1023, 1, 0, 0);
    tick_chk("abort.d4", 1100, 0, 0, 1, 0);

    // dwell=0 steps on every tick, amp_step=0 jumps to target
    cfg(1000, 1300, 100, 0, 4095, 0, 100, 1'b0);
    apply("dw0.start", 1000, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    tick_chk("dw0.t1", 1000, 4095, 1, 0, 0);
    tick_chk("dw0.t2", 1100, 4095, 1, 0, 0);
    tick_chk("dw0.t3", 1200, 4095, 1, 0, 0);
    tick_chk("dw0.t4", 1300, 4095, 1, 0, 0);
    tick_chk("dw0.t5", 1300, 4095, 1, 0, 0);
    tick_chk("dw0.t6", 1300, 0, 0, 1, 0);

    // f_step=0 holds f_start; start while busy is ignored
    cfg(500, 1300, 0, 1, 4095, 4095, 3, 1'b0);
    apply("fs0.start", 500, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    tick_chk("fs0.t1", 500, 4095, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick_chk("fs0.hold", 500, 4095, 1, 0, 0);
    cfg(777, 900, 50, 1, 100, 10, 3, 1'b1);
    apply("busy.start", 500, 4095, 1, 0, 0, 1'b1, 1'b0, 1'b1);
    apply("fs0.stop", 500, 4095, 1, 0, 0, 1'b0, 1'b1, 1'b0);
    tick_chk("fs0.down", 500, 0, 0, 1, 0);

    // start and stop together in IDLE
    cfg(900, 1300, 100, 1, 4095, 4095, 3, 1'b0);
    apply("startstop", 500, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    tick_chk("startstop.t", 500, 0, 0, 0, 0);

    // asynchronous reset mid-sweep, then a fresh sweep
    cfg(1000, 1300, 100, 2, 4095, 1024, 100, 1'b0);
    sweep_head("pre_rst", 8);
    #2 rst = 1'b0;
    #1 zero_chk("midrst");
    @(negedge clk) rst = 1'b1;
    cfg(2000, 2100, 100, 1, 100, 60, 7, 1'b0);
    apply("post.start", 2000, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    tick_chk("post.t1", 2000, 60, 1, 0, 0);
    tick_chk("post.t2", 2000, 100, 1, 0, 0);
    tick_chk("post.t3", 2100, 100, 1, 0, 0);
    tick_chk("post.t4", 2100, 100, 1, 0, 0);
    tick_chk("post.t5", 2100, 40, 1, 0, 0);
    tick_chk("post.t6", 2100, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the freq/phase/amp control inputs of the existing dds block to produce amplitude-ramped frequency sweeps. Configuration is latched on start. The block soft-starts the amplitude, steps the frequency word from f_start towards f_stop with a programmable dwell, then ramps the amplitude back down. All control-word updates are aligned to the DDS sample strobe (dac_start), so the DAC never sees a mid-sample change.

Parameters:
FW, 20, frequency word width (matches dds freq)
PW, 10, phase word width (matches dds phase)
AW, 12, amplitude width (matches dds amp)
DW, 16, dwell counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  1-cycle request to begin a sweep; honoured only in IDLE
stop  in  1  1-cycle abort request; forces RAMP_DOWN
mode  in  1  0 = single sweep, 1 = continuous (wraps to f_start)
f_start  in  FW  first frequency word
f_stop  in  FW  last frequency word (upper bound)
f_step  in  FW  frequency increment per dwell period
dwell  in  DW  dac_start ticks per frequency step; 0 is treated as 1
amp_target  in  AW  plateau amplitude
amp_step  in  AW  amplitude change per tick during ramps; 0 = jump in one tick
phase_in  in  PW  phase offset
dac_start  in  1  sample strobe from dds (the "tick")
freq  out  FW  to dds.freq
phase  out  PW  to dds.phase
amp  out  AW  to dds.amp
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse when RAMP_DOWN completes
wrap  out  1  1-cycle pulse when a continuous sweep restarts at f_start

Behaviour:
- Reset (rst=0, async): state=IDLE; freq=0, phase=0, amp=0, busy=0, done=0, wrap=0; dwell counter=0. Reset mid-sweep aborts immediately, with no ramp-down.
- All outputs are registered. A change caused by a tick appears on the clock edge after the cycle in which dac_start=1.
- IDLE:
  - start=1 and stop=0: latch all config inputs, freq<=f_start, phase<=phase_in, amp<=0, busy<=1, go to RAMP_UP. This takes effect on the next edge and does not wait for a tick.
  - start and stop high together: stop wins and nothing happens.
- RAMP_UP:
  - On each tick, amp<=min(amp+amp_step, amp_target), computed at AW+1 bits to avoid overflow.
  - When amp_step=0, amp<=amp_target on the first tick.
  - Go to SWEEP on the same edge that amp reaches amp_target.
  - If amp_target=0, go to SWEEP on the first tick.
- SWEEP:
  - On each tick, increment the dwell counter.
  - When the count equals max(dwell,1)-1: clear the counter and compute next=freq+f_step at FW+1 bits.
  - If next<=f_stop: freq<=next.
  - If next>f_stop, the sweep ends:
    - mode=1: freq<=f_start and wrap pulses.
    - mode=0: go to RAMP_DOWN with freq held.
  - f_step=0 holds freq at f_start until stop.
  - f_start>f_stop ends the sweep after the first dwell period.
- RAMP_DOWN:
  - On each tick, amp<=max(amp-amp_step, 0).
  - amp_step=0 clears amp in one tick.
  - When amp reaches 0, go to IDLE on the same edge: busy<=0, done=1 for one cycle. freq and phase keep their last values.
- stop=1 in RAMP_UP or SWEEP: go to RAMP_DOWN on the next edge, freq held. No freq step or amp change occurs on that edge, even if dac_start=1 in the same cycle. stop in RAMP_DOWN or IDLE has no effect.
- start while busy=1 is ignored. Config inputs are not re-sampled until the next accepted start.
- mode is sampled with the rest of the config at start.

Test Plan:
- Reset and idle: rst=0 for 100 ns, then release, with no start -> freq=0, phase=0, amp=0, busy=0 held indefinitely; ticks have no effect.
- Single sweep: f_start=1000, f_stop=1300, f_step=100, dwell=2, amp_target=4095, amp_step=1024, mode=0, phase_in=100, tick every 10 clk.
  - amp goes 1024, 2048, 3072, 4095 over 4 ticks.
  - freq goes 1000→1100→1200→1300, changing every 2 ticks.
  - After the 1300 dwell, amp ramps down 3071, 2047, 1023, 0.
  - done pulses once, then busy=0; phase=100 throughout.
- Continuous wrap: same config with mode=1 -> after the freq=1300 dwell, freq=1000 and wrap=1 for exactly one cycle; amp stays 4095; no done.
- Abort: stop asserted in the same cycle as a tick while freq=1100 in SWEEP -> next edge freq stays 1100, amp=4095, state RAMP_DOWN; amp reaches 0 after 4 ticks; done pulses.
- Edge cases:
  - dwell=0 -> freq steps on every tick.
  - amp_step=0 -> amp jumps 0→4095 on the first tick.
  - f_step=0 -> freq stuck at f_start until stop.
  - start+stop in the same cycle in IDLE -> busy stays 0.
- Reset mid-operation: rst=0 during SWEEP at freq=1200 -> all outputs 0 asynchronously, without waiting for a clk edge; after release, a new start sweeps correctly from f_start.
